// File: rtl/multicycle_cu.sv
// Main control FSM for the multi-cycle RV32 datapath: sequences fetch, decode,
// execute, memory and writeback over a shared ALU and unified memory.
module multicycle_cu #(
    parameter logic [6:0] OPC_R   = 7'b0110011,
    parameter logic [6:0] OPC_LW  = 7'b0000011,
    parameter logic [6:0] OPC_SW  = 7'b0100011,
    parameter logic [6:0] OPC_BEQ = 7'b1100011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_HALT     = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic        pc_write_s, pc_write_cond_s, ir_write_s;
    logic        mem_read_s, mem_write_s, reg_write_s;

    assign opcode = inst[6:0];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
        illegal_d = illegal_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OPC_LW || opcode == OPC_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OPC_R) begin
                    state_d = S_EXEC;
                end else if (opcode == OPC_BEQ) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                // IR is not reloaded after fetch, so the opcode is still valid here.
                state_d = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                state_d   = S_FETCH;
                instret_d = instret_q + 32'd1;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d   = S_FETCH;
                    instret_d = instret_q + 32'd1;
                end
            end
            S_EXEC: begin
                state_d = S_ALU_WB;
            end
            S_ALU_WB, S_BRANCH: begin
                state_d   = S_FETCH;
                instret_d = instret_q + 32'd1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d   = S_HALT;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Output decode from the current state (and mem_ready in FETCH).
    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        ir_write_s      = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        pc_source       = 2'b00;
        i_or_d          = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = SRCB_RS2;
        alu_op          = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                mem_read_s = 1'b1;
                alu_src_b  = SRCB_4;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BR;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read_s = 1'b1;
                i_or_d     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_s = 1'b1;
                i_or_d      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
                alu_src_a   = 1'b1;
                alu_op      = ALU_FUNCT;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = ALU_SUB;
                pc_write_cond_s = 1'b1;
                pc_source       = 2'b01;
            end
            default: begin
            end
        endcase
    end

    // Strobes are killed as soon as reset is asserted, before the reset edge.
    assign pc_write      = pc_write_s      & rst;
    assign pc_write_cond = pc_write_cond_s & rst;
    assign ir_write      = ir_write_s      & rst;
    assign mem_read      = mem_read_s      & rst;
    assign mem_write     = mem_write_s     & rst;
    assign reg_write     = reg_write_s     & rst;

    assign state   = state_q;
    assign instret = instret_q;
    assign illegal = illegal_q;

endmodule
